// File: rtl/cnt8_ctrl_if.sv
// Command, configuration and counter-link signals between the run controller and its host/counter.
interface cnt8_ctrl_if;
    localparam int unsigned W = 8;

    logic         start;
    logic         stop;
    logic         abort;
    logic [W-1:0] prescale;
    logic [W-1:0] limit;
    logic [W-1:0] cnt_in;
    logic         enable;
    logic         clear;
    logic         running;
    logic         done;

    modport master (
        output start, stop, abort, prescale, limit, cnt_in,
        input  enable, clear, running, done
    );

    modport slave (
        input  start, stop, abort, prescale, limit, cnt_in,
        output enable, clear, running, done
    );
endinterface

// File: rtl/cnt8_ctrl.sv
// Run controller for the 8-bit counter cnt8: prescaled enable, terminal-count stop,
// start/stop/abort command handling and a one-cycle done strobe.
module cnt8_ctrl (
    input  logic        clk,
    input  logic        res_n,
    cnt8_ctrl_if.slave  bus
);
    localparam int unsigned W  = 8;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S_IDLE  = 3'd0;
    localparam logic [SW-1:0] S_CLR   = 3'd1;
    localparam logic [SW-1:0] S_RUN   = 3'd2;
    localparam logic [SW-1:0] S_PAUSE = 3'd3;
    localparam logic [SW-1:0] S_DONE  = 3'd4;

    logic [SW-1:0] state_q, state_d;
    logic [W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [W-1:0]  presc_q, presc_d;
    logic [W-1:0]  lim_q, lim_d;
    logic          tick_c;
    logic          match_c;

    assign tick_c  = (pre_cnt_q == presc_q);
    // >= rather than == so an overshooting counter still stops the run
    assign match_c = (bus.cnt_in >= lim_q);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            presc_q   <= '0;
            lim_q     <= '0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            presc_q   <= presc_d;
            lim_q     <= lim_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        presc_d   = presc_q;
        lim_d     = lim_q;

        if (bus.abort) begin
            // no clear on abort: the counter keeps its value for readback
            state_d   = S_IDLE;
            pre_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d = S_CLR;
                        presc_d = bus.prescale;
                        lim_d   = bus.limit;
                    end
                end
                S_CLR: begin
                    state_d   = S_RUN;
                    pre_cnt_d = '0;
                end
                S_RUN: begin
                    pre_cnt_d = tick_c ? '0 : W'(pre_cnt_q + 8'd1);
                    if (match_c) begin
                        state_d = S_DONE;
                    end else if (bus.stop) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (bus.start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.clear   = (state_q == S_CLR);
    assign bus.running = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.enable  = (state_q == S_RUN) && tick_c && !match_c;

endmodule

// File: tb/tb_cnt8_ctrl.sv
// Bench for cnt8_ctrl paired with a behavioural cnt8; expected clear/enable/done
// cycles are queued at stimulus time and consumed by a negedge monitor.
module tb_cnt8_ctrl;
    logic clk   = 1'b0;
    logic res_n = 1'b1;
    always #5 clk = ~clk;

    cnt8_ctrl_if bus();

    cnt8_ctrl dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus)
    );

    // behavioural cnt8
    logic [7:0] cnt_q;
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)          cnt_q <= 8'd0;
        else if (bus.clear)  cnt_q <= 8'd0;
        else if (bus.enable) cnt_q <= cnt_q + 8'd1;
    end
    assign bus.cnt_in = cnt_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         at;
        logic [7:0] cnt;
    } done_t;

    int    clr_q[$];
    int    en_q[$];
    done_t done_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // expected outputs of an uninterrupted run started in cycle t
    task automatic push_run(input int t, input int p, input int l);
        clr_q.push_back(t + 1);
        for (int k = 1; k <= l; k++) en_q.push_back(t + 2 + k * (p + 1) - 1);
        done_q.push_back('{t + 3 + l * (p + 1), 8'(l)});
    endtask

    task automatic start_run(input logic [7:0] p, input logic [7:0] l);
        bus.prescale = p;
        bus.limit    = l;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // monitor: every clear/enable/done the DUT presents must match the next queued expectation
    always @(negedge clk) begin
        done_t d;
        if (res_n) begin
            if (bus.clear) begin
                if (clr_q.size() == 0) check("unexpected_clear", cyc, -1);
                else                   check("clear_cycle", cyc, clr_q.pop_front());
            end
            if (bus.enable) begin
                if (en_q.size() == 0) check("unexpected_enable", cyc, -1);
                else                  check("enable_cycle", cyc, en_q.pop_front());
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", cyc, -1);
                end else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.at);
                    check("done_cnt", int'(bus.cnt_in), int'(d.cnt));
                end
            end
        end
    end

    initial begin
        int t;
        bus.start    = 1'b1;
        bus.stop     = 1'b0;
        bus.abort    = 1'b0;
        bus.prescale = 8'd0;
        bus.limit    = 8'd0;
        res_n        = 1'b0;

        // reset held with start asserted
        repeat (3) @(negedge clk);
        check("rst_enable",  int'(bus.enable),  0);
        check("rst_clear",   int'(bus.clear),   0);
        check("rst_running", int'(bus.running), 0);
        check("rst_done",    int'(bus.done),    0);
        bus.start = 1'b0;
        res_n     = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_rst_running", int'(bus.running), 0);

        // basic run P=0 L=5
        t = cyc;
        push_run(t, 0, 5);
        start_run(8'd0, 8'd5);
        wait_cyc(t + 7);
        check("basic_cnt_t7", int'(bus.cnt_in), 5);
        wait_cyc(t + 12);
        check("basic_cnt_hold", int'(bus.cnt_in), 5);
        check("basic_idle_running", int'(bus.running), 0);

        // prescaled run P=3 L=2; config changes mid-run must not matter
        t = cyc;
        push_run(t, 3, 2);
        start_run(8'd3, 8'd2);
        bus.prescale = 8'd0;
        bus.limit    = 8'd200;
        wait_cyc(t + 14);
        check("presc_cnt_final", int'(bus.cnt_in), 2);

        // pause/resume P=0 L=10: stop while cnt_in=3 so the count holds at 4
        t = cyc;
        clr_q.push_back(t + 1);
        for (int c = t + 2; c <= t + 5; c++)  en_q.push_back(c);
        for (int c = t + 13; c <= t + 18; c++) en_q.push_back(c);
        done_q.push_back('{t + 20, 8'd10});
        start_run(8'd0, 8'd10);
        wait_cyc(t + 5);
        check("pause_cnt_at_stop", int'(bus.cnt_in), 3);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("pause_running", int'(bus.running), 0);
            check("pause_cnt_hold", int'(bus.cnt_in), 4);
            bus.stop  = (i == 2);
            bus.start = (i == 6);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("resume_running", int'(bus.running), 1);
        wait_cyc(t + 23);

        // L=0: no enable, done at t+3
        t = cyc;
        push_run(t, 0, 0);
        start_run(8'd0, 8'd0);
        wait_cyc(t + 6);

        // stop and match together: DONE wins
        t = cyc;
        push_run(t, 0, 3);
        start_run(8'd0, 8'd3);
        wait_cyc(t + 5);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        wait_cyc(t + 8);
        check("stopmatch_cnt", int'(bus.cnt_in), 3);

        // L=255 P=0: no wrap past the limit
        t = cyc;
        push_run(t, 0, 255);
        start_run(8'd0, 8'd255);
        wait_cyc(t + 262);
        check("l255_cnt_hold", int'(bus.cnt_in), 255);

        // abort in RUN at cnt_in=3 (P=3, between enable pulses)
        t = cyc;
        clr_q.push_back(t + 1);
        en_q.push_back(t + 5);
        en_q.push_back(t + 9);
        en_q.push_back(t + 13);
        start_run(8'd3, 8'd10);
        wait_cyc(t + 15);
        check("abort_cnt_before", int'(bus.cnt_in), 3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_running", int'(bus.running), 0);
        check("abort_enable",  int'(bus.enable),  0);
        check("abort_clear",   int'(bus.clear),   0);
        repeat (6) @(negedge clk);
        check("abort_cnt_hold", int'(bus.cnt_in), 3);

        // asynchronous reset mid-run
        t = cyc;
        clr_q.push_back(t + 1);
        en_q.push_back(t + 5);
        en_q.push_back(t + 9);
        start_run(8'd3, 8'd10);
        wait_cyc(t + 10);
        check("arst_running_before", int'(bus.running), 1);
        #2 res_n = 1'b0;
        #1;
        check("arst_enable",  int'(bus.enable),  0);
        check("arst_clear",   int'(bus.clear),   0);
        check("arst_running", int'(bus.running), 0);
        check("arst_done",    int'(bus.done),    0);
        @(negedge clk);
        res_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_idle_running", int'(bus.running), 0);

        // every queued expectation must have been consumed
        check("clear_queue_left",  clr_q.size(),  0);
        check("enable_queue_left", en_q.size(),   0);
        check("done_queue_left",   done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
